// File: rtl/bus_master_if.sv
// Single-transfer bus initiator: turns one CPU load/store into one bus cycle,
// decodes the top address nibble into a one-hot slave select, waits for the
// slave ack (or aborts on timeout), then reports data/error for one cycle.
//
// Handshake: the CPU holds cpu_req_i high; the request is accepted on the
// rising edge where the FSM is IDLE and cpu_req_i=1. cpu_stall_o is high while
// the request is pending or in flight. Completion is the one-cycle cpu_done_o
// pulse, with cpu_err_o/cpu_data_o qualified by it. On the bus side a cycle is
// active while bus_select_o is nonzero; the slave completes it with a
// one-cycle bus_ack_i, which is ignored when no cycle is active.
module bus_master_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int SEL_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              cpu_done_o,
    output logic              cpu_err_o,
    output logic              cpu_stall_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_we_o,
    output logic [SEL_W-1:0]  bus_select_o,
    input  logic [DATA_W-1:0] bus_data_i,
    input  logic              bus_ack_i,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Last WAIT count before the transfer is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [3:0]        idx;

    // State and bus-side registers; reset drops the bus cycle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: decode in IDLE, ack/timeout in WAIT, single-cycle RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        idx     = cpu_addr_i[ADDR_W-1 -: 4];

        unique case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    rdata_d = '0;
                    if (!idx[3]) begin
                        addr_d  = cpu_addr_i;
                        wdata_d = cpu_data_i;
                        we_d    = cpu_we_i;
                        sel_d   = SEL_W'(1) << idx[2:0];
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = S_WAIT;
                    end else begin
                        // Unmapped slave: no bus cycle, report error at once.
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_ack_i) begin
                    // Ack has priority over a timeout landing on the same cycle.
                    rdata_d = we_q ? '0 : bus_data_i;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus_addr_o   = addr_q;
    assign bus_data_o   = wdata_q;
    assign bus_we_o     = we_q;
    assign bus_select_o = sel_q;

    assign cpu_done_o  = (state_q == S_RESP);
    assign cpu_err_o   = (state_q == S_RESP) ? err_q : 1'b0;
    assign cpu_data_o  = (state_q == S_RESP) ? rdata_q : '0;
    assign cpu_stall_o = (state_q == S_WAIT) | ((state_q == S_IDLE) & cpu_req_i);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed bench for bus_master_if: expected completions are queued when a
// request is issued and checked by an independent monitor on each done pulse.
module tb_bus_master_if;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_data_i;
  logic [DATA_W-1:0] cpu_data_o;
  logic              cpu_done_o;
  logic              cpu_err_o;
  logic              cpu_stall_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_we_o;
  logic [SEL_W-1:0]  bus_select_o;
  logic [DATA_W-1:0] bus_data_i;
  logic              bus_ack_i;
  logic [1:0]        dbg_state_o;

  int n_cmp;
  int n_err;
  int n_done;

  // expected completion: {err, data}
  logic [DATA_W:0] exp_q[$];

  bus_master_if #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_done_o(cpu_done_o),
    .cpu_err_o(cpu_err_o), .cpu_stall_o(cpu_stall_o),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_we_o(bus_we_o), .bus_select_o(bus_select_o),
    .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_data_i = wd;
  endtask

  // scoreboard monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (cpu_done_o) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(cpu_done_o), 64'd0);
      end else begin
        check("completion", 64'({cpu_err_o, cpu_data_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; n_done = 0;
    rst_n = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    cpu_addr_i = '0; cpu_data_i = '0; bus_data_i = '0; bus_ack_i = 1'b0;
    #12;
    check("rst_select", 64'(bus_select_o), 64'd0);
    check("rst_outputs", 64'({cpu_done_o, cpu_err_o, cpu_stall_o, bus_we_o}), 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // 1: read slave 2, ack on the third WAIT cycle
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    issue(1'b0, 32'h2000_0010, 32'h0);
    #1 check("t1_stall_req", 64'(cpu_stall_o), 64'd1);
    tick(); cpu_req_i = 1'b0;
    check("t1_sel_w1", 64'(bus_select_o), 64'h0004);
    check("t1_addr", 64'(bus_addr_o), 64'h2000_0010);
    check("t1_we", 64'(bus_we_o), 64'd0);
    check("t1_stall_wait", 64'(cpu_stall_o), 64'd1);
    tick(); check("t1_sel_w2", 64'(bus_select_o), 64'h0004);
    tick(); check("t1_sel_w3", 64'(bus_select_o), 64'h0004);
    bus_ack_i = 1'b1; bus_data_i = 32'hDEAD_BEEF;
    tick(); bus_ack_i = 1'b0;
    check("t1_sel_resp", 64'(bus_select_o), 64'd0);
    check("t1_done", 64'(cpu_done_o), 64'd1);
    check("t1_stall_resp", 64'(cpu_stall_o), 64'd0);
    tick(); check("t1_done_gone", 64'(cpu_done_o), 64'd0);

    // 2: write slave 7, ack on the first WAIT cycle
    exp_q.push_back({1'b0, 32'h0});
    issue(1'b1, 32'h7000_0004, 32'h1234_5678);
    tick(); cpu_req_i = 1'b0;
    check("t2_sel", 64'(bus_select_o), 64'h0080);
    check("t2_we", 64'(bus_we_o), 64'd1);
    check("t2_wdata", 64'(bus_data_o), 64'h1234_5678);
    bus_ack_i = 1'b1; bus_data_i = 32'hFFFF_0000;
    tick(); bus_ack_i = 1'b0;
    check("t2_sel_clr", 64'(bus_select_o), 64'd0);
    check("t2_we_clr", 64'(bus_we_o), 64'd0);
    check("t2_done", 64'(cpu_done_o), 64'd1);
    tick();

    // 3: decode error
    exp_q.push_back({1'b1, 32'h0});
    issue(1'b0, 32'h9000_0000, 32'h0);
    tick(); cpu_req_i = 1'b0;
    check("t3_sel", 64'(bus_select_o), 64'd0);
    check("t3_done", 64'(cpu_done_o), 64'd1);
    tick();

    // 4: timeout after 8 WAIT cycles, data forced to zero
    exp_q.push_back({1'b1, 32'h0});
    bus_data_i = 32'hCAFE_CAFE;
    issue(1'b0, 32'h1000_0000, 32'h0);
    tick(); cpu_req_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_sel_%0d", i), 64'(bus_select_o), 64'h0002);
      tick();
    end
    check("t4_sel_clr", 64'(bus_select_o), 64'd0);
    check("t4_done", 64'(cpu_done_o), 64'd1);
    tick();

    // 5: asynchronous reset in the middle of a write
    issue(1'b1, 32'h3000_0000, 32'h5555_AAAA);
    tick(); cpu_req_i = 1'b0;
    check("t5_sel", 64'(bus_select_o), 64'h0008);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_sel", 64'(bus_select_o), 64'd0);
    check("t5_rst_we", 64'(bus_we_o), 64'd0);
    check("t5_rst_done_stall", 64'({cpu_done_o, cpu_stall_o}), 64'd0);
    check("t5_rst_state", 64'(dbg_state_o), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    exp_q.push_back({1'b0, 32'hA5A5_0001});
    issue(1'b0, 32'h0000_0100, 32'h0);
    tick(); cpu_req_i = 1'b0;
    check("t5_sel0", 64'(bus_select_o), 64'h0001);
    bus_ack_i = 1'b1; bus_data_i = 32'hA5A5_0001;
    tick(); bus_ack_i = 1'b0;
    check("t5_done", 64'(cpu_done_o), 64'd1);
    tick();

    // 6: back-to-back reads with req held, stray acks in IDLE
    exp_q.push_back({1'b0, 32'h1111_1111});
    exp_q.push_back({1'b0, 32'h2222_2222});
    issue(1'b0, 32'h0000_0000, 32'h0);
    tick();
    check("t6_sel_a", 64'(bus_select_o), 64'h0001);
    cpu_addr_i = 32'h1000_0000;
    bus_ack_i = 1'b1; bus_data_i = 32'h1111_1111;
    tick(); bus_ack_i = 1'b0;
    check("t6_resp_stall", 64'({cpu_done_o, cpu_stall_o}), 64'b10);
    tick();
    check("t6_idle", 64'({cpu_done_o, cpu_stall_o, bus_select_o}), {46'd0, 2'b01, 16'd0});
    bus_ack_i = 1'b1; bus_data_i = 32'h0BAD_0BAD;
    tick(); bus_ack_i = 1'b0; cpu_req_i = 1'b0;
    check("t6_sel_b", 64'(bus_select_o), 64'h0002);
    check("t6_no_early_done", 64'(cpu_done_o), 64'd0);
    bus_ack_i = 1'b1; bus_data_i = 32'h2222_2222;
    tick(); bus_ack_i = 1'b0;
    check("t6_done_b", 64'(cpu_done_o), 64'd1);
    tick();
    bus_ack_i = 1'b1;
    tick(); tick();
    bus_ack_i = 1'b0;
    check("t6_stray_ack", 64'({cpu_done_o, bus_select_o}), 64'd0);
    tick(); tick();

    check("done_count", 64'(n_done), 64'd7);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
